// File: rtl/uart_parity_tx.sv
// uart_parity_tx
// Serial transmitter for the parity-enabled UART. Each accepted request is
// sent as one frame: start bit (0), DBIT data bits LSB first, one parity bit,
// then stop bits (1). All timing comes from the 16x oversampling s_tick.
//
// Parameters:
//   DBIT       - data bits per frame (1..8)
//   SB_TICK    - s_ticks spent in the stop state (16/24/32 -> 1/1.5/2 stop bits)
//   PARITY_ODD - 0 = even parity, 1 = odd parity
//
// Ports:
//   clk          in  1  system clock, rising edge
//   reset        in  1  synchronous, active-high reset
//   tx_start     in  1  send request, only looked at in IDLE
//   s_tick       in  1  baud tick, one clk wide, 16 per bit period
//   din          in  8  data word, bits [DBIT-1:0] are sent
//   tx_done_tick out 1  one-clk pulse as the frame ends
//   tx_busy      out 1  high whenever the transmitter is not idle
//   tx           out 1  registered serial line, idles high
module uart_parity_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // The tick counter is 5 bits wide so a 2-stop-bit setting (32 ticks)
  // counts naturally instead of relying on 4-bit wraparound.
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  state_t          state, state_next;
  logic [4:0]      s, s_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            p, p_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      b        <= '0;
      p        <= 1'b0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      s        <= s_next;
      n        <= n_next;
      b        <= b_next;
      p        <= p_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    p_next     = p;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        // A tick arriving together with the request is deliberately not
        // counted: tick phase starts at acceptance.
        if (tx_start) begin
          b_next     = din[DBIT-1:0];
          p_next     = (^din[DBIT-1:0]) ^ PARITY_ODD;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == N_LAST) begin
              state_next = PARITY;
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s == BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == STOP_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line level is derived from where the FSM is going, so the registered
  // tx changes on exactly the edge that moves the FSM between bits.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_done_tick = done_reg;
  assign tx_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_parity_tx.sv
// tb_uart_parity_tx
// Directed bench for uart_parity_tx. Three instances cover the default
// configuration, odd parity, and 2 stop bits with a slow baud tick. A frame
// task drives one request and compares tx/tx_busy/tx_done_tick every clock
// against a tick-counting model of the frame.
module tb_uart_parity_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       s_tick;
  logic [7:0] din;
  int         sel;

  logic start_def, start_odd, start_sb;
  logic tx_def, busy_def, done_def;
  logic tx_odd, busy_odd, done_odd;
  logic tx_sb, busy_sb, done_sb;
  logic tx_m, busy_m, done_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign start_def = start && (sel == 0);
  assign start_odd = start && (sel == 1);
  assign start_sb  = start && (sel == 2);

  assign tx_m   = (sel == 0) ? tx_def   : (sel == 1) ? tx_odd   : tx_sb;
  assign busy_m = (sel == 0) ? busy_def : (sel == 1) ? busy_odd : busy_sb;
  assign done_m = (sel == 0) ? done_def : (sel == 1) ? done_odd : done_sb;

  uart_parity_tx u_def (
    .clk(clk), .reset(reset), .tx_start(start_def), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_def), .tx_busy(busy_def), .tx(tx_def)
  );

  uart_parity_tx #(.PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .reset(reset), .tx_start(start_odd), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_odd), .tx_busy(busy_odd), .tx(tx_odd)
  );

  uart_parity_tx #(.SB_TICK(32)) u_sb (
    .clk(clk), .reset(reset), .tx_start(start_sb), .s_tick(s_tick), .din(din),
    .tx_done_tick(done_sb), .tx_busy(busy_sb), .tx(tx_sb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Sends d on the selected instance; period is the
  // s_tick spacing in clocks, sb the stop-state tick count. hold keeps
  // tx_start high through the frame; scramble toggles tx_start and din.
  task automatic frame(input string name, input logic [7:0] d, input logic par,
                       input int period, input int sb, input bit hold, input bit scramble);
    int   ticks;
    int   frame_end;
    int   limit;
    int   idx;
    bit   tick_drv;
    bit   finished;
    logic exp_tx;
    ticks     = 0;
    frame_end = 160 + sb;
    limit     = frame_end * period + 20;
    finished  = 1'b0;
    din       = d;
    start     = 1'b1;
    s_tick    = (period == 1);
    for (int c = 1; c <= limit; c++) begin
      tick_drv = s_tick;
      @(negedge clk);
      if (c >= 2 && tick_drv) ticks++;
      idx = ticks / 16;
      if (ticks == frame_end) begin
        chk($sformatf("%s tx c=%0d", name, c), tx_m, 1);
        chk($sformatf("%s busy c=%0d", name, c), busy_m, 0);
        chk($sformatf("%s done c=%0d", name, c), done_m, 1);
        finished = 1'b1;
        break;
      end
      if (idx == 0)      exp_tx = 1'b0;
      else if (idx <= 8) exp_tx = d[idx-1];
      else if (idx == 9) exp_tx = par;
      else               exp_tx = 1'b1;
      chk($sformatf("%s tx c=%0d", name, c), tx_m, exp_tx);
      chk($sformatf("%s busy c=%0d", name, c), busy_m, 1);
      chk($sformatf("%s done c=%0d", name, c), done_m, 0);
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        din   = 8'($urandom);
      end else begin
        start = hold;
      end
      s_tick = (period == 1) ? 1'b1 : ((c % period) == 0);
    end
    chk($sformatf("%s frame completed", name), finished, 1);
  endtask

  task automatic idle_check(input string name, input int cycles);
    start  = 1'b0;
    s_tick = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s idle tx i=%0d", name, i), tx_m, 1);
      chk($sformatf("%s idle busy i=%0d", name, i), busy_m, 0);
      chk($sformatf("%s idle done i=%0d", name, i), done_m, 0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    s_tick = 1'b0;
    din    = 8'h00;
    sel    = 0;
    repeat (3) @(negedge clk);
    chk("reset tx_def", tx_def, 1);
    chk("reset busy_def", busy_def, 0);
    chk("reset done_def", done_def, 0);
    chk("reset tx_odd", tx_odd, 1);
    chk("reset busy_odd", busy_odd, 0);
    chk("reset tx_sb", tx_sb, 1);
    chk("reset busy_sb", busy_sb, 0);
    reset = 1'b0;
    @(negedge clk);

    // Default even parity, tick every clock.
    sel = 0;
    frame("even55", 8'h55, 1'b0, 1, 16, 1'b0, 1'b0);
    idle_check("even55", 3);

    // Odd parity instance.
    sel = 1;
    frame("odd55", 8'h55, 1'b1, 1, 16, 1'b0, 1'b0);
    idle_check("odd55", 2);
    frame("odd07", 8'h07, 1'b0, 1, 16, 1'b0, 1'b0);
    idle_check("odd07", 2);
    frame("odd00", 8'h00, 1'b1, 1, 16, 1'b0, 1'b0);
    idle_check("odd00", 2);

    // Back-to-back: tx_start held, new word presented in the done cycle.
    sel = 0;
    frame("b2b_a3", 8'hA3, 1'b0, 1, 16, 1'b1, 1'b0);
    frame("b2b_3c", 8'h3C, 1'b0, 1, 16, 1'b0, 1'b0);
    idle_check("b2b", 20);

    // Slow tick, 2 stop bits.
    sel = 2;
    frame("sb32_ff", 8'hFF, 1'b0, 163, 32, 1'b0, 1'b0);
    idle_check("sb32", 3);

    // Reset while in data bit 3 (bit 3 of 0x96 is 0).
    sel    = 0;
    din    = 8'h96;
    start  = 1'b1;
    s_tick = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midframe tx bit3", tx_m, 0);
    chk("midframe busy", busy_m, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("after reset tx", tx_m, 1);
    chk("after reset busy", busy_m, 0);
    chk("after reset done", done_m, 0);
    reset = 1'b0;
    idle_check("post_reset", 150);
    frame("post_reset96", 8'h96, 1'b0, 1, 16, 1'b0, 1'b0);
    idle_check("post_reset96", 3);

    // Toggle tx_start and din during the frame; 0x0B has 3 ones -> parity 1.
    frame("scramble0b", 8'h0B, 1'b1, 1, 16, 1'b0, 1'b1);
    idle_check("scramble", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
